// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// the per-stage control bundle and the NOP instruction word.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  // addi x0, x0, 0: what a flushed pipeline register holds.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_write: 1'b1,
    idex_flush: 1'b0, exmem_write: 1'b1, memwb_flush: 1'b0
  };

  localparam ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b0,
    idex_flush: 1'b0, exmem_write: 1'b0, memwb_flush: 1'b1
  };

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges branch redirects,
// load-use hazards and data-memory waits into per-stage enables and flushes.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = pipeline_hazard_ctrl_pkg::REG_ADDR_W,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch_taken,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  dmem_req,
  input  logic                  dmem_ack,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_flush,
  output logic                  exmem_write,
  output logic                  memwb_flush,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  import pipeline_hazard_ctrl_pkg::*;

  localparam int FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [FC_W-1:0] fcnt, fcnt_nxt;
  logic [WC_W-1:0] wcnt, wcnt_nxt;
  ctrl_t           ctrl;
  logic            lu, freeze_req, run_eval, err_set, flush_inc;

  assign lu = idex_mem_read && (idex_rd != '0) &&
              ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
  assign freeze_req = dmem_req && !dmem_ack;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    ctrl      = CTRL_RUN;
    state_nxt = state;
    fcnt_nxt  = fcnt;
    wcnt_nxt  = wcnt;
    err_set   = 1'b0;
    flush_inc = 1'b0;
    run_eval  = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (freeze_req) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = MEM_WAIT;
          end else begin
            run_eval = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!dmem_ack) begin
            ctrl     = CTRL_FREEZE;
            wcnt_nxt = wcnt + WC_W'(1);
            if (wcnt_nxt == WC_W'(MEM_TIMEOUT)) begin
              // Access abandoned: drop any pending flush and resume fetching.
              err_set   = 1'b1;
              wcnt_nxt  = '0;
              fcnt_nxt  = '0;
              state_nxt = RUN;
            end
          end else begin
            wcnt_nxt  = '0;
            state_nxt = (fcnt != '0) ? FLUSH : RUN;
            run_eval  = 1'b1;
          end
        end
        FLUSH: begin
          if (freeze_req) begin
            ctrl      = CTRL_FREEZE;
            state_nxt = MEM_WAIT;
          end else if (!branch_taken) begin
            ctrl.ifid_flush = 1'b1;
            fcnt_nxt        = fcnt - FC_W'(1);
            if (fcnt == FC_W'(1)) state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase

      // A branch in FLUSH reloads the window; lu only matters outside FLUSH,
      // where ID holds a squashed bubble.
      if (branch_taken && (run_eval || ((state == FLUSH) && !freeze_req))) begin
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
        flush_inc       = 1'b1;
        if (FLUSH_DEPTH > 1) begin
          fcnt_nxt  = FC_W'(FLUSH_DEPTH - 1);
          state_nxt = FLUSH;
        end
      end else if (lu && run_eval) begin
        ctrl.pc_write   = 1'b0;
        ctrl.ifid_write = 1'b0;
        ctrl.idex_flush = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      fcnt    <= '0;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      wcnt  <= wcnt_nxt;
      if (err_set) mem_err <= 1'b1;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_write  = ctrl.idex_write;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_write = ctrl.exmem_write;
  assign memwb_flush = ctrl.memwb_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (!ctrl.pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
